// File: rtl/pong_engine.sv
// pong_engine: frame-rate core for two-player pong.
// Owns paddles, ball, scores, serve/play/pause/over FSM.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per frame, advances the game
//   p1_up/p1_dn/p1_srv    player 1 controls (levels)
//   p2_up/p2_dn/p2_srv    player 2 controls (levels)
//   p1_y, p2_y            paddle centre y
//   ball_x, ball_y        ball centre
//   score1, score2        per-player scores (saturating)
//   state                 FSM encoding
//   evt_wall/paddle/point one-cycle event pulses
//   game_over             high while in OVER
module pong_engine #(
   parameter int FIELD_W      = 640,
   parameter int FIELD_H      = 480,
   parameter int PAD_H        = 50,
   parameter int PAD_W        = 8,
   parameter int BALL_SZ      = 8,
   parameter int P1_X         = 40,
   parameter int P2_X         = 600,
   parameter int P_SPD        = 4,
   parameter int B_SPD        = 2,
   parameter int MAX_SCORE    = 9,
   parameter int PAUSE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       p1_up,
   input  logic       p1_dn,
   input  logic       p1_srv,
   input  logic       p2_up,
   input  logic       p2_dn,
   input  logic       p2_srv,
   output logic [9:0] p1_y,
   output logic [9:0] p2_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [2:0] state,
   output logic       evt_wall,
   output logic       evt_paddle,
   output logic       evt_point,
   output logic       game_over
);

   typedef enum logic [2:0] {
      ST_SERVE_P1 = 3'd0,
      ST_SERVE_P2 = 3'd1,
      ST_PLAY     = 3'd2,
      ST_PAUSE    = 3'd3,
      ST_OVER     = 3'd4
   } state_t;

   localparam int LP_CW = $clog2(PAUSE_FRAMES + 1);

   localparam logic signed [11:0] LP_HB    = 12'(BALL_SZ / 2);
   localparam logic signed [11:0] LP_BSPD  = 12'(B_SPD);
   localparam logic signed [11:0] LP_PSPD  = 12'(P_SPD);
   localparam logic signed [11:0] LP_FH1   = 12'(FIELD_H - 1);
   localparam logic signed [11:0] LP_FW1   = 12'(FIELD_W - 1);
   localparam logic signed [11:0] LP_TOPY  = 12'(BALL_SZ / 2);
   localparam logic signed [11:0] LP_BOTY  = 12'(FIELD_H - 1 - BALL_SZ / 2);
   localparam logic signed [11:0] LP_P1R   = 12'(P1_X + PAD_W / 2);
   localparam logic signed [11:0] LP_P2L   = 12'(P2_X - PAD_W / 2);
   localparam logic signed [11:0] LP_REACH = 12'((PAD_H + BALL_SZ) / 2);
   localparam logic signed [11:0] LP_PMIN  = 12'(PAD_H / 2);
   localparam logic signed [11:0] LP_PMAX  = 12'(FIELD_H - PAD_H / 2);

   localparam logic [9:0] LP_CX     = 10'(FIELD_W / 2);
   localparam logic [9:0] LP_CY     = 10'(FIELD_H / 2);
   localparam logic [9:0] LP_P1HITX = 10'(P1_X + PAD_W / 2 + BALL_SZ / 2);
   localparam logic [9:0] LP_P2HITX = 10'(P2_X - PAD_W / 2 - BALL_SZ / 2);
   localparam logic [3:0] LP_MAX    = 4'(MAX_SCORE);
   localparam logic [LP_CW-1:0] LP_PLOAD = LP_CW'(PAUSE_FRAMES - 1);

   state_t           r_state;
   logic [9:0]       r_p1y, r_p2y, r_bx, r_by;
   logic             r_vx_neg, r_vy_neg;
   logic [3:0]       r_score1, r_score2;
   logic [LP_CW-1:0] r_pcnt;
   logic             r_p2_conceded;
   logic             r_srv1_q, r_srv2_q;
   logic             r_evt_wall, r_evt_paddle, r_evt_point;
   logic             r_game_over;

   logic              w_rise1, w_rise2;
   logic [9:0]        w_p1n, w_p2n;
   logic signed [11:0] w_bx, w_by, w_p1s, w_p2s;
   logic signed [11:0] w_nx, w_ny0, w_ny;
   logic signed [11:0] w_dy1, w_dy2, w_ady1, w_ady2;
   logic              w_vy_neg, w_wall;
   logic              w_hit1, w_hit2, w_miss1, w_miss2;

   // Signed step then clamp, so a paddle can never wrap past an edge.
   function automatic logic [9:0] f_pad(
      input logic [9:0] y,
      input logic       up,
      input logic       dn
   );
      logic signed [11:0] t;
      t = $signed({2'b00, y});
      if (dn && !up) t = t + LP_PSPD;
      else if (up && !dn) t = t - LP_PSPD;
      if (t < LP_PMIN) t = LP_PMIN;
      else if (t > LP_PMAX) t = LP_PMAX;
      return t[9:0];
   endfunction

   assign w_rise1 = p1_srv & ~r_srv1_q;
   assign w_rise2 = p2_srv & ~r_srv2_q;
   assign w_p1n   = f_pad(r_p1y, p1_up, p1_dn);
   assign w_p2n   = f_pad(r_p2y, p2_up, p2_dn);

   always_comb begin
      w_bx  = $signed({2'b00, r_bx});
      w_by  = $signed({2'b00, r_by});
      w_p1s = $signed({2'b00, r_p1y});
      w_p2s = $signed({2'b00, r_p2y});
      w_nx  = r_vx_neg ? (w_bx - LP_BSPD) : (w_bx + LP_BSPD);
      w_ny0 = r_vy_neg ? (w_by - LP_BSPD) : (w_by + LP_BSPD);
      w_ny     = w_ny0;
      w_vy_neg = r_vy_neg;
      w_wall   = 1'b0;
      if (w_ny0 - LP_HB <= 12'sd0) begin
         w_ny     = LP_TOPY;
         w_vy_neg = 1'b0;
         w_wall   = 1'b1;
      end else if (w_ny0 + LP_HB >= LP_FH1) begin
         w_ny     = LP_BOTY;
         w_vy_neg = 1'b1;
         w_wall   = 1'b1;
      end
      // Paddle reach is judged on the post-bounce y.
      w_dy1  = w_ny - w_p1s;
      w_dy2  = w_ny - w_p2s;
      w_ady1 = (w_dy1 < 12'sd0) ? -w_dy1 : w_dy1;
      w_ady2 = (w_dy2 < 12'sd0) ? -w_dy2 : w_dy2;
      // Hit only while crossing the paddle face this frame,
      // so a ball already behind the paddle cannot be rescued.
      w_hit1 = r_vx_neg
             && (w_nx - LP_HB <= LP_P1R)
             && (w_bx - LP_HB > LP_P1R - LP_BSPD)
             && (w_ady1 <= LP_REACH);
      w_hit2 = !r_vx_neg
             && (w_nx + LP_HB >= LP_P2L)
             && (w_bx + LP_HB < LP_P2L + LP_BSPD)
             && (w_ady2 <= LP_REACH);
      w_miss1 = !w_hit1 && !w_hit2
              && (w_nx - LP_HB <= 12'sd0);
      w_miss2 = !w_hit1 && !w_hit2 && !w_miss1
              && (w_nx + LP_HB >= LP_FW1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_SERVE_P1;
         r_p1y         <= LP_CY;
         r_p2y         <= LP_CY;
         r_bx          <= LP_CX;
         r_by          <= LP_CY;
         r_vx_neg      <= 1'b0;
         r_vy_neg      <= 1'b0;
         r_score1      <= 4'd0;
         r_score2      <= 4'd0;
         r_pcnt        <= '0;
         r_p2_conceded <= 1'b0;
         r_srv1_q      <= 1'b0;
         r_srv2_q      <= 1'b0;
         r_evt_wall    <= 1'b0;
         r_evt_paddle  <= 1'b0;
         r_evt_point   <= 1'b0;
         r_game_over   <= 1'b0;
      end else begin
         r_srv1_q     <= p1_srv;
         r_srv2_q     <= p2_srv;
         r_evt_wall   <= 1'b0;
         r_evt_paddle <= 1'b0;
         r_evt_point  <= 1'b0;
         if (frame_tick && r_state != ST_OVER) begin
            r_p1y <= w_p1n;
            r_p2y <= w_p2n;
         end
         unique case (r_state)
            ST_SERVE_P1: begin
               if (w_rise1) begin
                  r_state  <= ST_PLAY;
                  r_vx_neg <= 1'b0;
                  r_vy_neg <= 1'b0;
               end
            end
            ST_SERVE_P2: begin
               if (w_rise2) begin
                  r_state  <= ST_PLAY;
                  r_vx_neg <= 1'b1;
                  r_vy_neg <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (frame_tick) begin
                  r_by       <= w_ny[9:0];
                  r_vy_neg   <= w_vy_neg;
                  r_evt_wall <= w_wall;
                  if (w_hit1) begin
                     r_bx         <= LP_P1HITX;
                     r_vx_neg     <= 1'b0;
                     r_evt_paddle <= 1'b1;
                  end else if (w_hit2) begin
                     r_bx         <= LP_P2HITX;
                     r_vx_neg     <= 1'b1;
                     r_evt_paddle <= 1'b1;
                  end else if (w_miss1 || w_miss2) begin
                     r_bx          <= LP_CX;
                     r_by          <= LP_CY;
                     r_evt_point   <= 1'b1;
                     r_state       <= ST_PAUSE;
                     r_pcnt        <= LP_PLOAD;
                     r_p2_conceded <= w_miss2;
                     if (w_miss1 && r_score2 != LP_MAX)
                        r_score2 <= r_score2 + 4'd1;
                     if (w_miss2 && r_score1 != LP_MAX)
                        r_score1 <= r_score1 + 4'd1;
                  end else begin
                     r_bx <= w_nx[9:0];
                  end
               end
            end
            ST_PAUSE: begin
               if (frame_tick) begin
                  if (r_pcnt != '0) begin
                     r_pcnt <= r_pcnt - LP_CW'(1);
                  end else if (r_score1 == LP_MAX
                            || r_score2 == LP_MAX) begin
                     r_state     <= ST_OVER;
                     r_game_over <= 1'b1;
                  end else begin
                     r_state <= r_p2_conceded ? ST_SERVE_P2
                                              : ST_SERVE_P1;
                  end
               end
            end
            ST_OVER: begin
               if (w_rise1 || w_rise2) begin
                  r_state     <= ST_SERVE_P1;
                  r_game_over <= 1'b0;
                  r_score1    <= 4'd0;
                  r_score2    <= 4'd0;
                  r_p1y       <= LP_CY;
                  r_p2y       <= LP_CY;
                  r_bx        <= LP_CX;
                  r_by        <= LP_CY;
                  r_vx_neg    <= 1'b0;
                  r_vy_neg    <= 1'b0;
               end
            end
            default: r_state <= ST_SERVE_P1;
         endcase
      end
   end

   assign p1_y       = r_p1y;
   assign p2_y       = r_p2y;
   assign ball_x     = r_bx;
   assign ball_y     = r_by;
   assign score1     = r_score1;
   assign score2     = r_score2;
   assign state      = r_state;
   assign evt_wall   = r_evt_wall;
   assign evt_paddle = r_evt_paddle;
   assign evt_point  = r_evt_point;
   assign game_over  = r_game_over;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed bench for pong_engine.
// Linear scenario sequence with hand-computed trajectories.
module tb_pong_engine;

   localparam int S_SP1   = 0;
   localparam int S_SP2   = 1;
   localparam int S_PLAY  = 2;
   localparam int S_PAUSE = 3;
   localparam int S_OVER  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       p1_up = 1'b0, p1_dn = 1'b0, p1_srv = 1'b0;
   logic       p2_up = 1'b0, p2_dn = 1'b0, p2_srv = 1'b0;
   logic [9:0] p1_y, p2_y, ball_x, ball_y;
   logic [3:0] score1, score2;
   logic [2:0] state;
   logic       evt_wall, evt_paddle, evt_point, game_over;

   int n_checks = 0;
   int n_errors = 0;

   pong_engine dut (
      .clk       (clk),
      .rst       (rst),
      .frame_tick(frame_tick),
      .p1_up     (p1_up),
      .p1_dn     (p1_dn),
      .p1_srv    (p1_srv),
      .p2_up     (p2_up),
      .p2_dn     (p2_dn),
      .p2_srv    (p2_srv),
      .p1_y      (p1_y),
      .p2_y      (p2_y),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .score1    (score1),
      .score2    (score2),
      .state     (state),
      .evt_wall  (evt_wall),
      .evt_paddle(evt_paddle),
      .evt_point (evt_point),
      .game_over (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse frame_tick for one cycle; returns at the negedge
   // right after the update, while any event pulse is high.
   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic srv(input bit p2);
      @(negedge clk);
      if (p2) p2_srv = 1'b1;
      else p1_srv = 1'b1;
      @(negedge clk);
      p1_srv = 1'b0;
      p2_srv = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".p1_y"}, p1_y, 240);
      chk({tag, ".p2_y"}, p2_y, 240);
      chk({tag, ".bx"}, ball_x, 320);
      chk({tag, ".by"}, ball_y, 240);
      chk({tag, ".s1"}, score1, 0);
      chk({tag, ".s2"}, score2, 0);
      chk({tag, ".state"}, state, S_SP1);
      chk({tag, ".ewall"}, evt_wall, 0);
      chk({tag, ".epad"}, evt_paddle, 0);
      chk({tag, ".epnt"}, evt_point, 0);
      chk({tag, ".over"}, game_over, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;

      // Paddle 1 up to clamp, both buttons cancel
      p1_up = 1'b1;
      tick();
      chk("pad.step1", p1_y, 236);
      ticks(52);
      chk("pad.step53", p1_y, 28);
      tick();
      chk("pad.clamp54", p1_y, 25);
      ticks(6);
      chk("pad.hold60", p1_y, 25);
      chk("pad.p2", p2_y, 240);
      chk("pad.park_x", ball_x, 320);
      p1_dn = 1'b1;
      ticks(3);
      chk("pad.both", p1_y, 25);
      p1_up = 1'b0;
      p1_dn = 1'b0;

      // Serve handling: wrong server ignored
      srv(1'b1);
      chk("srv.ignore2", state, S_SP1);
      srv(1'b0);
      chk("srv.play1", state, S_PLAY);

      // P1 serve, bottom wall, P2 misses (p2_y=240)
      ticks(117);
      chk("w1.y117", ball_y, 474);
      chk("w1.nowall", evt_wall, 0);
      tick();
      chk("w1.y", ball_y, 475);
      chk("w1.x", ball_x, 556);
      chk("w1.evt", evt_wall, 1);
      @(negedge clk);
      chk("w1.evt_len", evt_wall, 0);
      ticks(18);
      chk("m2.x136", ball_x, 592);
      chk("m2.y136", ball_y, 439);
      chk("m2.nohit", evt_paddle, 0);
      ticks(21);
      chk("m2.x157", ball_x, 634);
      chk("m2.play", state, S_PLAY);
      tick();
      chk("m2.epnt", evt_point, 1);
      chk("m2.s1", score1, 1);
      chk("m2.s2", score2, 0);
      chk("m2.bx", ball_x, 320);
      chk("m2.by", ball_y, 240);
      chk("m2.pause", state, S_PAUSE);
      ticks(59);
      chk("m2.pause59", state, S_PAUSE);
      chk("m2.frozen", ball_x, 320);
      tick();
      chk("m2.srv2", state, S_SP2);

      // P2 serves leftward, P1 misses (p1_y=25)
      srv(1'b0);
      chk("srv.ignore1", state, S_SP2);
      srv(1'b1);
      chk("srv.play2", state, S_PLAY);
      ticks(118);
      chk("w2.x", ball_x, 84);
      chk("w2.y", ball_y, 475);
      chk("w2.evt", evt_wall, 1);
      ticks(40);
      chk("m1.epnt", evt_point, 1);
      chk("m1.s2", score2, 1);
      chk("m1.s1", score1, 1);
      ticks(60);
      chk("m1.srv1", state, S_SP1);

      // P2 paddle parked at 455 returns, P1 misses; to 9
      p2_dn = 1'b1;
      for (int r = 0; r < 8; r++) begin
         srv(1'b0);
         chk($sformatf("r%0d.play", r), state, S_PLAY);
         ticks(136);
         chk($sformatf("r%0d.epad", r), evt_paddle, 1);
         chk($sformatf("r%0d.hitx", r), ball_x, 592);
         chk($sformatf("r%0d.hity", r), ball_y, 439);
         chk($sformatf("r%0d.p2y", r), p2_y, 455);
         chk($sformatf("r%0d.s2h", r), score2, r + 1);
         ticks(218);
         chk($sformatf("r%0d.topy", r), ball_y, 4);
         chk($sformatf("r%0d.topx", r), ball_x, 156);
         chk($sformatf("r%0d.ewall", r), evt_wall, 1);
         ticks(76);
         chk($sformatf("r%0d.epnt", r), evt_point, 1);
         chk($sformatf("r%0d.s2", r), score2, r + 2);
         chk($sformatf("r%0d.s1", r), score1, 1);
         ticks(60);
         if (r < 7)
            chk($sformatf("r%0d.next", r), state, S_SP1);
      end
      chk("over.state", state, S_OVER);
      chk("over.flag", game_over, 1);

      // OVER freezes paddles; any srv edge restarts
      p1_dn = 1'b1;
      ticks(5);
      chk("over.p1", p1_y, 25);
      chk("over.p2", p2_y, 455);
      chk("over.bx", ball_x, 320);
      chk("over.state2", state, S_OVER);
      p1_dn = 1'b0;
      p2_dn = 1'b0;
      srv(1'b1);
      chk_reset("restart");

      // Reset coincident with a wall-bounce tick
      srv(1'b0);
      p1_up = 1'b1;
      ticks(117);
      chk("mid.p1", p1_y, 25);
      chk("mid.y", ball_y, 474);
      @(negedge clk);
      frame_tick = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      rst = 1'b0;
      p1_up = 1'b0;
      chk_reset("midrst");

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
